// File: rtl/sad_wta_select.sv
// Winner-take-all disparity selector: running-minimum SAD search with a one-entry output register.
// Optional uniqueness check enabled by defining WTA_UNIQ_EN.
module sad_wta_select #(
    parameter int SAD_W      = 12,
    parameter int DISP_NUM   = 16,
    parameter int DISP_W     = $clog2(DISP_NUM),
    parameter int UNIQ_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SAD_W-1:0]  sad_in,
    input  logic              sad_valid,
    output logic              sad_ready,
    output logic [DISP_W-1:0] disp_out,
    output logic [SAD_W-1:0]  min_sad_out,
    output logic              disp_ok,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [DISP_W-1:0] D_LAST  = DISP_W'(DISP_NUM - 1);
    localparam logic [SAD_W-1:0]  SAD_MAX = '1;

    logic [DISP_W-1:0] d_cnt;
    logic [DISP_W-1:0] best_d;
    logic [DISP_W-1:0] nxt_d;
    logic [SAD_W-1:0]  best_sad;
    logic [SAD_W-1:0]  nxt_best;
    logic              accept;
    logic              first;
    logic              last;
    logic              better;
    logic              fin_ok;

    // Conservative stall: hold input whenever the output slot cannot drain.
    assign sad_ready = !(out_valid && !out_ready);
    assign accept    = sad_valid && sad_ready;
    assign first     = (d_cnt == '0);
    assign last      = (d_cnt == D_LAST);
    assign better    = (sad_in < best_sad);

    always_comb begin
        nxt_best = best_sad;
        nxt_d    = best_d;
        if (first) begin
            nxt_best = sad_in;
            nxt_d    = '0;
        end else if (better) begin
            nxt_best = sad_in;
            nxt_d    = d_cnt;
        end
    end

`ifdef WTA_UNIQ_EN
    logic [SAD_W-1:0] second_sad;
    logic [SAD_W-1:0] nxt_second;
    logic [SAD_W-1:0] margin;

    always_comb begin
        nxt_second = second_sad;
        if (first) begin
            nxt_second = SAD_MAX;
        end else if (better) begin
            nxt_second = best_sad;
        end else if (sad_in < second_sad) begin
            nxt_second = sad_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_sad <= SAD_MAX;
        end else if (accept) begin
            second_sad <= nxt_second;
        end
    end

    // second >= best always holds, so the subtraction never wraps.
    assign margin = nxt_best >> UNIQ_SHIFT;
    assign fin_ok = (nxt_second == SAD_MAX) ||
                    ((nxt_second - nxt_best) > margin);
`else
    assign fin_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_cnt    <= '0;
            best_sad <= '0;
            best_d   <= '0;
        end else if (accept) begin
            d_cnt    <= last ? '0 : d_cnt + 1'b1;
            best_sad <= nxt_best;
            best_d   <= nxt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_out    <= '0;
            min_sad_out <= '0;
            disp_ok     <= 1'b0;
            out_valid   <= 1'b0;
        end else if (accept && last) begin
            disp_out    <= nxt_d;
            min_sad_out <= nxt_best;
            disp_ok     <= fin_ok;
            out_valid   <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
